// File: rtl/traffic_control_2.sv
// traffic_control_2 -- highway / country-road junction controller.
//
// A six-phase Moore FSM with one phase timer. The highway stays green
// until a country car is waiting and the minimum green has elapsed. The
// country road then gets green until it clears or the maximum green runs
// out. Every handover goes through yellow and then all-red.
//
// Parameters
//   TW            phase timer width in bits
//   Y_TIME        cycles per yellow phase
//   RR_TIME       cycles per all-red clearance phase
//   HW_MIN_GREEN  minimum highway-green cycles before serving the country road
//   CNT_MAX_GREEN maximum country-green cycles
//
// Ports
//   clk      single clock, rising edge
//   reset    synchronous active-high reset (to highway green, timer 0)
//   x        country-road car sensor, sampled at every edge
//   hi_way   highway lamp       (00 red, 01 yellow, 10 green)
//   cnt_way  country-road lamp  (same encoding)
//   state_o  current state code, for debug
module traffic_control_2 #(
  parameter int TW            = 8,
  parameter int Y_TIME        = 3,
  parameter int RR_TIME       = 2,
  parameter int HW_MIN_GREEN  = 8,
  parameter int CNT_MAX_GREEN = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       x,
  output logic [1:0] hi_way,
  output logic [1:0] cnt_way,
  output logic [2:0] state_o
);

  localparam logic [2:0] S0_HWY_GREEN  = 3'd0;
  localparam logic [2:0] S1_HWY_YELLOW = 3'd1;
  localparam logic [2:0] S2_ALL_RED_A  = 3'd2;
  localparam logic [2:0] S3_CNT_GREEN  = 3'd3;
  localparam logic [2:0] S4_CNT_YELLOW = 3'd4;
  localparam logic [2:0] S5_ALL_RED_B  = 3'd5;

  localparam logic [1:0] LAMP_RED    = 2'b00;
  localparam logic [1:0] LAMP_YELLOW = 2'b01;
  localparam logic [1:0] LAMP_GREEN  = 2'b10;

  // Last timer value of each timed phase.
  localparam logic [TW-1:0] HW_LAST  = TW'(HW_MIN_GREEN - 1);
  localparam logic [TW-1:0] Y_LAST   = TW'(Y_TIME - 1);
  localparam logic [TW-1:0] RR_LAST  = TW'(RR_TIME - 1);
  localparam logic [TW-1:0] CNT_LAST = TW'(CNT_MAX_GREEN - 1);

  logic [2:0]    state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S0_HWY_GREEN;
      timer_reg <= '0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg + 1'b1;
    case (state_reg)
      S0_HWY_GREEN: begin
        if (timer_reg >= HW_LAST) begin
          // Once the minimum green has elapsed, hold the timer at its last
          // value so an arbitrarily long highway green never wraps it.
          timer_next = HW_LAST;
          if (x) begin
            state_next = S1_HWY_YELLOW;
            timer_next = '0;
          end
        end
      end
      S1_HWY_YELLOW: begin
        if (timer_reg == Y_LAST) begin
          state_next = S2_ALL_RED_A;
          timer_next = '0;
        end
      end
      S2_ALL_RED_A: begin
        if (timer_reg == RR_LAST) begin
          state_next = S3_CNT_GREEN;
          timer_next = '0;
        end
      end
      S3_CNT_GREEN: begin
        // End country green as soon as the road is empty or it has used
        // its maximum share.
        if (!x || (timer_reg == CNT_LAST)) begin
          state_next = S4_CNT_YELLOW;
          timer_next = '0;
        end
      end
      S4_CNT_YELLOW: begin
        if (timer_reg == Y_LAST) begin
          state_next = S5_ALL_RED_B;
          timer_next = '0;
        end
      end
      S5_ALL_RED_B: begin
        if (timer_reg == RR_LAST) begin
          state_next = S0_HWY_GREEN;
          timer_next = '0;
        end
      end
      default: begin
        // Unused codes recover to highway green.
        state_next = S0_HWY_GREEN;
        timer_next = '0;
      end
    endcase
  end

  // Lamps decode the state register only. x has no path to the outputs.
  always_comb begin
    hi_way  = LAMP_RED;
    cnt_way = LAMP_RED;
    case (state_reg)
      S0_HWY_GREEN:  hi_way  = LAMP_GREEN;
      S1_HWY_YELLOW: hi_way  = LAMP_YELLOW;
      S3_CNT_GREEN:  cnt_way = LAMP_GREEN;
      S4_CNT_YELLOW: cnt_way = LAMP_YELLOW;
      default: begin
        hi_way  = LAMP_RED;
        cnt_way = LAMP_RED;
      end
    endcase
  end

  assign state_o = state_reg;

endmodule

// File: doc/traffic_control_2.md
TRAFFIC_CONTROL_2 -- requirements
Module: traffic_control_2

Interface
REQ-001 Parameter TW, default 8: width of the phase timer in bits.
REQ-002 Parameter Y_TIME, default 3: number of cycles each yellow phase lasts.
REQ-003 Parameter RR_TIME, default 2: number of cycles each all-red clearance phase lasts.
REQ-004 Parameter HW_MIN_GREEN, default 8: minimum number of highway-green cycles before a country request is served.
REQ-005 Parameter CNT_MAX_GREEN, default 10: maximum number of country-green cycles.
REQ-006 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-007 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 Port x, input, 1 bit: country-road car sensor; 1 means a car is waiting or present.
REQ-009 Port hi_way, output, 2 bits: highway lamp, encoded 2'b00 RED, 2'b01 YELLOW, 2'b10 GREEN.
REQ-010 Port cnt_way, output, 2 bits: country-road lamp, same encoding as hi_way.
REQ-011 Port state_o, output, 3 bits: current FSM state code, for debug.
REQ-012 Parameter legality: all four time parameters SHALL be at least 1 and at most 2^TW-1; the bench checks this at elaboration.

Function
REQ-013 The FSM SHALL have six states with these codes and lamp values (hi_way/cnt_way):
- S0 HWY_GREEN = 0: GREEN/RED
- S1 HWY_YELLOW = 1: YELLOW/RED
- S2 ALL_RED_A = 2: RED/RED
- S3 CNT_GREEN = 3: RED/GREEN
- S4 CNT_YELLOW = 4: RED/YELLOW
- S5 ALL_RED_B = 5: RED/RED
REQ-014 hi_way, cnt_way and state_o SHALL be a pure function of the state register (Moore), with no combinational path from x.
REQ-015 The timer SHALL be 0 in the first cycle of every state and SHALL increment by 1 each cycle the state is held.
REQ-016 In S0 the timer SHALL saturate at HW_MIN_GREEN-1; it SHALL never wrap in any state.
REQ-017 S0 SHALL go to S1 on the edge where x==1 and timer>=HW_MIN_GREEN-1; otherwise it SHALL stay in S0 indefinitely.
REQ-018 S1 and S4 SHALL each last exactly Y_TIME cycles (exit when timer==Y_TIME-1), going S1->S2 and S4->S5.
REQ-019 S2 and S5 SHALL each last exactly RR_TIME cycles, going S2->S3 and S5->S0.
REQ-020 S3 SHALL go to S4 on the first edge where x==0 or timer==CNT_MAX_GREEN-1, so country green lasts 1 to CNT_MAX_GREEN cycles.
REQ-021 x SHALL be sampled afresh at every edge and never latched.
- x changing during S1, S2, S4 or S5 SHALL NOT alter the phase sequence or its timing.
REQ-022 Both roads SHALL never show GREEN or YELLOW simultaneously; every handover SHALL pass through an all-red state.
REQ-023 Unused state codes 6 and 7 SHALL go to S0 with timer 0 on the next edge.

Reset
REQ-024 While reset==1 at an edge, the next state SHALL be S0 with timer 0, giving hi_way=2'b10, cnt_way=2'b00, state_o=0.
REQ-025 Reset SHALL take priority over all transitions, including mid-yellow and mid-country-green.
REQ-026 After reset deasserts, the S0 minimum-green count SHALL start from 0.

Verification (default parameters)
REQ-027 Scenario: reset high for 5 edges, then x=0 for 50 cycles -> hi_way=10 and cnt_way=00 throughout; state_o=0.
REQ-028 Scenario: x=1 from the first cycle after reset -> S0 holds 8 cycles, then hi_way=01 for 3 cycles, then 00/00 for 2 cycles, then cnt_way=10.
REQ-029 Scenario: x held at 1 -> cnt_way=10 for exactly 10 cycles, then cnt_way=01 for 3, then 00/00 for 2, then hi_way=10 again.
REQ-030 Scenario: x drops to 0 in the 4th cycle of S3 -> cnt_way=01 starting the next cycle (4 green cycles total), and x rising during S4 has no effect.
REQ-031 Scenario: reset pulsed for 1 edge during S3 -> the next cycle shows hi_way=10, cnt_way=00, state_o=0, and with x=1 S0 again holds 8 cycles.
REQ-032 Scenario: random x over 10,000 cycles -> assertion of REQ-022, with each phase duration within REQ-017 to REQ-020 bounds.
